// File: rtl/core_pipe_stage.sv
// core_pipe_stage: valid/ready pipeline register with a two-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
//
// State table
//   state | meaning
//   EMPTY | nothing held, out_valid = 0
//   ONE   | main_q holds the oldest bundle
//   FULL  | main_q oldest, skid_q next; in_ready = 0
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream bundle present
//   in_ready   stage can accept (decoded from registered state)
//   in_data    upstream bundle
//   out_valid  bundle available downstream (decoded from registered state)
//   out_ready  downstream accepts
//   out_data   oldest held bundle (main_q)
//   occupancy  held entries, 0..2 (equals the state encoding)
//   clr_cnt    synchronous clear of stall_cnt
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready
module core_pipe_stage #(
  parameter int DATA_W = 77,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              load_main_in, load_main_skid, load_skid;
  logic              in_fire, out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Data registers may still load during a flush; the entry is dropped
    // because the state returns to EMPTY, which is cheaper than gating the
    // enables and leaves out_data meaningless anyway.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_pipe_stage.sv
// Directed bench for core_pipe_stage: reset, single transfer, streaming,
// skid fill/drain, flush while FULL, counter saturation/clear, async reset.
module tb_core_pipe_stage;
  localparam int DATA_W = 77;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic              clr_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  core_pipe_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] occ, input logic iv_rdy,
                             input logic ov);
    check({tag, "_occ"}, 80'(occupancy), 80'(occ));
    check({tag, "_in_ready"}, 80'(in_ready), 80'(iv_rdy));
    check({tag, "_out_valid"}, 80'(out_valid), 80'(ov));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    #3;
    check_state("reset", 2'd0, 1'b1, 1'b0);
    check("reset_data", 80'(out_data), 80'h0);
    check("reset_cnt", 80'(stall_cnt), 80'h0);
    #4 rst = 1'b1;
    step();

    // single transfer
    in_valid = 1'b1; in_data = 77'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_state("single", 2'd1, 1'b1, 1'b1);
    check("single_data", 80'(out_data), 80'hA5);
    step();
    check_state("single_after", 2'd0, 1'b1, 1'b0);

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 77'(i);
      step();
      check("stream_data", 80'(out_data), 80'(i));
      check("stream_in_ready", 80'(in_ready), 80'h1);
      check("stream_out_valid", 80'(out_valid), 80'h1);
    end
    in_valid = 1'b0;
    step();
    check("stream_occ", 80'(occupancy), 80'h0);
    check("stream_cnt", 80'(stall_cnt), 80'h0);

    // skid fill and drain
    in_valid = 1'b1; in_data = 77'h1; out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_data = 77'h2;
    step();
    check_state("skid_full", 2'd2, 1'b0, 1'b1);
    check("skid_data1", 80'(out_data), 80'h1);
    in_data = 77'h3;
    step();
    check_state("skid_hold", 2'd2, 1'b0, 1'b1);
    step();
    check("skid_cnt3", 80'(stall_cnt), 80'h3);
    out_ready = 1'b1;
    step();
    check_state("skid_drain2", 2'd1, 1'b1, 1'b1);
    check("skid_data2", 80'(out_data), 80'h2);
    step();
    in_valid = 1'b0;
    check("skid_data3", 80'(out_data), 80'h3);
    check("skid_occ3", 80'(occupancy), 80'h1);
    step();
    check_state("skid_empty", 2'd0, 1'b1, 1'b0);
    check("skid_cnt", 80'(stall_cnt), 80'h3);

    // flush while FULL with an in_valid attempt
    out_ready = 1'b0; in_valid = 1'b1; in_data = 77'h11;
    step();
    in_data = 77'h22;
    step();
    check_state("pre_flush", 2'd2, 1'b0, 1'b1);
    flush = 1'b1; in_data = 77'h33;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_state("flush", 2'd0, 1'b1, 1'b0);
    step();
    check_state("flush_stay", 2'd0, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 77'h55; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_state("post_flush", 2'd1, 1'b1, 1'b1);
    check("post_flush_data", 80'(out_data), 80'h55);
    step();
    check_state("post_flush_empty", 2'd0, 1'b1, 1'b0);

    // flush in ONE with simultaneous in_fire discards the new bundle
    in_valid = 1'b1; in_data = 77'h61; out_ready = 1'b0;
    step();
    flush = 1'b1; in_data = 77'h62;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_state("flush_one", 2'd0, 1'b1, 1'b0);

    // counter saturation and clear
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_idle", 80'(stall_cnt), 80'h0);
    in_valid = 1'b1; in_data = 77'h77; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("sat_start", 80'(stall_cnt), 80'h0);
    for (int i = 0; i < 20; i++) step();
    check("sat_15", 80'(stall_cnt), 80'hF);
    check("sat_data", 80'(out_data), 80'h77);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_stalled", 80'(stall_cnt), 80'h0);
    step();
    check("count_after_clr", 80'(stall_cnt), 80'h1);

    // asynchronous reset mid-stream while FULL
    in_valid = 1'b1; in_data = 77'h88;
    step();
    in_valid = 1'b0;
    check_state("pre_async", 2'd2, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_state("async_rst", 2'd0, 1'b1, 1'b0);
    check("async_data", 80'(out_data), 80'h0);
    check("async_cnt", 80'(stall_cnt), 80'h0);
    #2 rst = 1'b1;
    step();
    check_state("after_async", 2'd0, 1'b1, 1'b0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 77'h99;
    step();
    in_valid = 1'b0;
    check("after_async_data", 80'(out_data), 80'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/core_pipe_stage.md
# core_pipe_stage

Parametrised pipeline-stage register for the core datapath, the successor to the fixed-field EX/MEM latch. It carries an opaque `DATA_W`-bit stage bundle (ALU result, store data, destination register, control bits) between two pipeline stages using a valid/ready handshake. A two-entry skid buffer keeps `in_ready` free of any combinational dependence on `out_ready`. It also supports synchronous flush for branch/exception squash and provides a saturating back-pressure counter for performance monitoring.

## Interface
Parameters:
- `DATA_W`, 77, width of the stage bundle (32 alu_result + 32 reg_read2 + 5 dest_reg + 8 control bits).
- `CNT_W`, 16, width of the stall counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream has a bundle.
- `in_ready`  out  1  stage can accept a bundle this cycle.
- `in_data`  in  DATA_W  upstream bundle.
- `out_valid`  out  1  bundle available to downstream.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  bundle presented downstream (the oldest held entry).
- `occupancy`  out  2  number of held entries, 0..2.
- `clr_cnt`  in  1  synchronous clear of `stall_cnt`.
- `stall_cnt`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Storage is `main_q` (drives `out_data`) and `skid_q`. The state register is EMPTY (0), ONE (1) or FULL (2); `occupancy` equals the state encoding.
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- `in_ready = (state != FULL)`; `out_valid = (state != EMPTY)`. Both are decoded from registered state only.
- Transitions when `flush` = 0:
  - EMPTY: on `in_fire`, `main_q <= in_data` and go to ONE; otherwise stay.
  - ONE:
    - `in_fire & out_fire`: `main_q <= in_data`, stay ONE.
    - `in_fire` only: `skid_q <= in_data`, go to FULL.
    - `out_fire` only: go to EMPTY.
    - Neither: hold.
  - FULL: `in_fire` is impossible. On `out_fire`, `main_q <= skid_q` and go to ONE; otherwise hold.
- Flush has the highest priority:
  - `flush` = 1 forces `state <= EMPTY` next cycle, whatever the other inputs.
  - A bundle accepted by `in_fire` in the flush cycle is discarded. Upstream must treat it as squashed.
  - An `out_fire` in the flush cycle counts as delivered.
  - `main_q` and `skid_q` are not cleared by flush.
- Ordering is strict FIFO. No bundle is duplicated or reordered.
- `out_data` is meaningful only while `out_valid` = 1. Otherwise it holds its last registered value.
- Stall counter:
  - Increments by 1 in each cycle where `out_valid & ~out_ready`.
  - Saturates at 2^CNT_W − 1.
  - `clr_cnt` forces 0 next cycle and wins over a simultaneous increment.
  - `flush` does not affect the counter.

## Timing
- Reset (`rst` = 0, asynchronous) sets:
  - state = EMPTY, so `in_ready` = 1, `out_valid` = 0, `occupancy` = 0;
  - `main_q` = `skid_q` = 0, so `out_data` = 0;
  - `stall_cnt` = 0.
- Reset mid-operation drops all held entries immediately, without waiting for a clock edge.
- Latency: `in_fire` at edge N gives `out_valid` = 1 with that data after edge N (1 cycle) when the stage was EMPTY or ONE-with-`out_fire`.
- Throughput: one bundle per cycle sustained while `out_ready` = 1.
- Back-pressure: a held bundle reaches FULL one cycle after `out_ready` deasserts, provided upstream keeps `in_valid` = 1. `in_ready` drops the cycle after FULL is entered; no bundle is lost.
- No combinational path from `in_valid`/`in_data` to any output, nor from `out_ready` to `in_ready`.

## Test plan
- **Reset then single transfer.** Deassert `rst`, then drive `in_valid` = 1 with `in_data` = 0x…A5 for one cycle, `out_ready` = 1 → next cycle `out_valid` = 1 and `out_data` = 0x…A5; the following cycle `out_valid` = 0 and `occupancy` = 0.
- **Streaming.** Drive 8 back-to-back bundles 1..8 with `out_ready` held 1 → `out_data` sequence 1..8 on consecutive cycles, `in_ready` constantly 1, `stall_cnt` = 0.
- **Skid fill and drain.** Stream 1,2,3 with `out_ready` = 0 from the second cycle → `occupancy` reaches 2 and `in_ready` = 0, so 3 is held off. Then raise `out_ready` → outputs 1, 2, 3 in order and `stall_cnt` equals the number of stalled cycles.
- **Flush while FULL with a simultaneous `in_fire` attempt.** → next cycle `occupancy` = 0, `out_valid` = 0, and no flushed bundle ever appears; a subsequent bundle 0x55 emerges normally.
- **Counter saturation and clear.** With `CNT_W` = 4, hold `out_valid` = 1 and `out_ready` = 0 for 20 cycles → `stall_cnt` = 15. Then assert `clr_cnt` while still stalled → 0 next cycle.
- **Asynchronous reset mid-stream.** Pulse `rst` low between clock edges while FULL → outputs return to reset values immediately; after release the stage is EMPTY with `in_ready` = 1.
